// File: rtl/hsi_frame_ctrl.sv
// hsi_frame_ctrl: frame-level sequencer between rgb2hsi and the VGA outputs.
// Enables the image generator, aligns start/stop to frame boundaries,
// counts frames, checks frame geometry and muxes one HSI channel to VGA.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle request to begin streaming (IDLE only)
//   stop       single-cycle request to end streaming after current frame
//   chan_sel   0=H, 1=S, 2/3=I; latched on frame start
//   HSI_hsync  line sync from rgb2hsi, active high
//   HSI_vsync  frame sync from rgb2hsi, active high
//   HSI_de     data enable from rgb2hsi
//   H_data     hue
//   S_data     saturation
//   I_data     intensity
//   gen_en     enable back to the image generator
//   VGA_hsync  hsync delayed one cycle
//   VGA_vsync  vsync delayed one cycle
//   VGA_de     data enable delayed one cycle, gated to RUN/DRAIN
//   VGA_data   selected channel while VGA_de, else 0
//   busy       state is not IDLE
//   frame_cnt  completed frames since the last start
//   geo_err    sticky geometry-mismatch flag

module hsi_frame_ctrl #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int FRAMES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  chan_sel,
    input  logic        HSI_hsync,
    input  logic        HSI_vsync,
    input  logic        HSI_de,
    input  logic [7:0]  H_data,
    input  logic [7:0]  S_data,
    input  logic [7:0]  I_data,
    output logic        gen_en,
    output logic        VGA_hsync,
    output logic        VGA_vsync,
    output logic        VGA_de,
    output logic [7:0]  VGA_data,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        geo_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [11:0] LP_H      = 12'(H_DISP);
    localparam logic [11:0] LP_V      = 12'(V_DISP);
    localparam logic [15:0] LP_FRAMES = 16'(FRAMES);
    localparam bit          LP_LIMIT  = (FRAMES != 0);
    localparam logic [11:0] LP_SAT    = 12'hFFF;

    state_t      r_state;
    state_t      w_next;

    logic        r_vs_d1;
    logic        r_hs_d1;
    logic        r_de_d1;
    logic        r_gen_en;
    logic        r_busy;
    logic        r_stop_pend;
    logic        r_geo_err;
    logic [1:0]  r_chan_q;
    logic [15:0] r_frame_cnt;
    logic [11:0] r_pix_cnt;
    logic [11:0] r_line_cnt;
    logic        r_vga_de;
    logic [7:0]  r_vga_data;

    logic        w_vs_rise;
    logic        w_de_fall;
    logic        w_start_go;
    logic        w_arm_go;
    logic        w_run_close;
    logic        w_cnt_en;
    logic        w_stream;
    logic        w_gate;
    logic        w_last;
    logic        w_pix_bad;
    logic        w_line_bad;
    logic [15:0] w_cnt_inc;
    logic [7:0]  w_sel;

    assign w_vs_rise   = HSI_vsync & ~r_vs_d1;
    assign w_de_fall   = r_de_d1 & ~HSI_de;
    assign w_start_go  = (r_state == S_IDLE) & start;
    // stop takes precedence over a frame start while still armed
    assign w_arm_go    = (r_state == S_ARM) & w_vs_rise & ~stop;
    assign w_run_close = (r_state == S_RUN) & w_vs_rise;
    assign w_cnt_en    = (r_state != S_IDLE);
    assign w_stream    = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign w_gate      = HSI_de & w_stream;
    assign w_cnt_inc   = r_frame_cnt + 16'd1;
    assign w_last      = LP_LIMIT & (w_cnt_inc == LP_FRAMES);
    assign w_pix_bad   = w_de_fall & w_stream & (r_pix_cnt != LP_H);
    assign w_line_bad  = w_run_close & (r_line_cnt != LP_V);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ARM;
            end
            S_ARM: begin
                if (stop)           w_next = S_IDLE;
                else if (w_vs_rise) w_next = S_RUN;
            end
            S_RUN: begin
                // a stop coinciding with the closing edge still drains
                if (w_vs_rise && (r_stop_pend || stop || w_last))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_vs_rise) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel = I_data;
        case (r_chan_q)
            2'd0:    w_sel = H_data;
            2'd1:    w_sel = S_data;
            default: w_sel = I_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_gen_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != S_IDLE);
            r_gen_en <= (w_next == S_ARM) | (w_next == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
            r_stop_pend <= 1'b0;
            r_chan_q    <= 2'd0;
            r_geo_err   <= 1'b0;
        end else begin
            if (w_start_go)
                r_frame_cnt <= 16'd0;
            else if (w_run_close)
                r_frame_cnt <= w_cnt_inc;

            if (w_next == S_IDLE)
                r_stop_pend <= 1'b0;
            else if ((r_state == S_RUN) && stop)
                r_stop_pend <= 1'b1;

            if (w_arm_go || w_run_close)
                r_chan_q <= chan_sel;

            if (w_start_go)
                r_geo_err <= 1'b0;
            else if (w_pix_bad || w_line_bad)
                r_geo_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= 12'd0;
            r_line_cnt <= 12'd0;
        end else begin
            if (!w_cnt_en || w_vs_rise || w_de_fall)
                r_pix_cnt <= 12'd0;
            else if (HSI_de && (r_pix_cnt != LP_SAT))
                r_pix_cnt <= r_pix_cnt + 12'd1;

            if (!w_cnt_en || w_vs_rise)
                r_line_cnt <= 12'd0;
            else if (w_de_fall && (r_line_cnt != LP_SAT))
                r_line_cnt <= r_line_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1    <= 1'b0;
            r_hs_d1    <= 1'b0;
            r_de_d1    <= 1'b0;
            r_vga_de   <= 1'b0;
            r_vga_data <= 8'h00;
        end else begin
            r_vs_d1    <= HSI_vsync;
            r_hs_d1    <= HSI_hsync;
            r_de_d1    <= HSI_de;
            r_vga_de   <= w_gate;
            r_vga_data <= w_gate ? w_sel : 8'h00;
        end
    end

    assign gen_en    = r_gen_en;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;
    assign geo_err   = r_geo_err;
    assign VGA_hsync = r_hs_d1;
    assign VGA_vsync = r_vs_d1;
    assign VGA_de    = r_vga_de;
    assign VGA_data  = r_vga_data;

endmodule

// File: tb/tb_hsi_frame_ctrl.sv
// tb_hsi_frame_ctrl: directed scoreboard bench for hsi_frame_ctrl.
// u_dut runs continuous (FRAMES=0); u_dut2 runs two frames (FRAMES=2).

module tb_hsi_frame_ctrl;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        start2;
    logic        stop2;
    logic [1:0]  chan_sel;
    logic        hs;
    logic        vs;
    logic        de;
    logic [7:0]  hd;
    logic [7:0]  sd;
    logic [7:0]  id;

    logic        gen_en;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [7:0]  vga_data;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        geo_err;

    logic        gen_en2;
    logic        vga_hs2;
    logic        vga_vs2;
    logic        vga_de2;
    logic [7:0]  vga_data2;
    logic        busy2;
    logic [15:0] frame_cnt2;
    logic        geo_err2;

    int          checks;
    int          errors;
    bit          stream;
    logic [1:0]  exp_chan;
    logic [7:0]  q[$];

    hsi_frame_ctrl #(.H_DISP(H), .V_DISP(V), .FRAMES(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .chan_sel(chan_sel), .HSI_hsync(hs), .HSI_vsync(vs), .HSI_de(de),
        .H_data(hd), .S_data(sd), .I_data(id),
        .gen_en(gen_en), .VGA_hsync(vga_hs), .VGA_vsync(vga_vs),
        .VGA_de(vga_de), .VGA_data(vga_data), .busy(busy),
        .frame_cnt(frame_cnt), .geo_err(geo_err)
    );

    hsi_frame_ctrl #(.H_DISP(H), .V_DISP(V), .FRAMES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2),
        .chan_sel(chan_sel), .HSI_hsync(hs), .HSI_vsync(vs), .HSI_de(de),
        .H_data(hd), .S_data(sd), .I_data(id),
        .gen_en(gen_en2), .VGA_hsync(vga_hs2), .VGA_vsync(vga_vs2),
        .VGA_de(vga_de2), .VGA_data(vga_data2), .busy(busy2),
        .frame_cnt(frame_cnt2), .geo_err(geo_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [1:0] c);
        case (c)
            2'd0:    return 8'hA5;
            2'd1:    return 8'h5A;
            default: return 8'h3C;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("start_gen_en", 32'(gen_en), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic pulse_stop();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic send_vs();
        step();
        vs = 1'b1;
        exp_chan = chan_sel;
        step();
        step();
        vs = 1'b0;
        step();
    endtask

    task automatic send_lines(input int n, input int short_l,
                              input int sw_l, input logic [1:0] sw_v);
        for (int l = 0; l < n; l++) begin
            if (l == sw_l) chan_sel = sw_v;
            step();
            step();
            for (int p = 0; p < ((l == short_l) ? H - 1 : H); p++) begin
                step();
                de = 1'b1;
                if (stream) q.push_back(exp_data(exp_chan));
            end
            step();
            de = 1'b0;
            hs = 1'b1;
            if (l == short_l) begin
                @(negedge clk);
                chk("geo_before_fall", 32'(geo_err), 32'd0);
            end
            step();
            hs = 1'b0;
            if (l == short_l) begin
                @(negedge clk);
                chk("geo_after_fall", 32'(geo_err), 32'd1);
            end
        end
    endtask

    logic prev_ok;
    logic prev_hs;
    logic prev_vs;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (vga_de) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL vga_de_unexpected: got de=1 data=%0h expected de=0",
                             vga_data);
                end else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    if (vga_data !== e) begin
                        errors++;
                        $display("FAIL vga_data: got %0h expected %0h",
                                 vga_data, e);
                    end
                end
            end else begin
                checks++;
                if (vga_data !== 8'h00) begin
                    errors++;
                    $display("FAIL vga_data_idle: got %0h expected 0", vga_data);
                end
            end
            if (prev_ok) begin
                checks++;
                if (vga_hs !== prev_hs || vga_vs !== prev_vs) begin
                    errors++;
                    $display("FAIL sync_delay: got hs=%0b vs=%0b expected hs=%0b vs=%0b",
                             vga_hs, vga_vs, prev_hs, prev_vs);
                end
            end
            prev_hs = hs;
            prev_vs = vs;
            prev_ok = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        stream = 1'b0;
        exp_chan = 2'd0;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        start2 = 1'b0;
        stop2 = 1'b0;
        chan_sel = 2'd2;
        hs = 1'b0;
        vs = 1'b0;
        de = 1'b0;
        hd = 8'hA5;
        sd = 8'h5A;
        id = 8'h3C;

        repeat (3) step();
        @(negedge clk);
        chk("rst_gen_en", 32'(gen_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_geo_err", 32'(geo_err), 32'd0);
        chk("rst_vga_de", 32'(vga_de), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        step();
        rst_n = 1'b1;

        pulse_stop();
        @(negedge clk);
        chk("idle_stop_ignored", 32'(busy), 32'd0);

        // three frames with stop during frame 3, channel I
        pulse_start();
        stream = 1'b1;
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        chk("t1_cnt1", 32'(frame_cnt), 32'd1);
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        chk("t1_cnt2", 32'(frame_cnt), 32'd2);
        pulse_stop();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        chk("t1_drain_cnt", 32'(frame_cnt), 32'd3);
        chk("t1_drain_gen_en", 32'(gen_en), 32'd0);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        stream = 1'b0;
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_final_cnt", 32'(frame_cnt), 32'd3);
        chk("t1_geo", 32'(geo_err), 32'd0);

        // channel switch mid-frame only takes effect on next frame
        chan_sel = 2'd1;
        pulse_start();
        stream = 1'b1;
        send_vs();
        send_lines(V, -1, 1, 2'd0);
        send_vs();
        pulse_stop();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        stream = 1'b0;
        @(negedge clk);
        chk("t2_cnt", 32'(frame_cnt), 32'd2);
        chk("t2_busy", 32'(busy), 32'd0);

        // FRAMES=2 instance drains on its own
        step();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        @(negedge clk);
        chk("t3_gen_en2", 32'(gen_en2), 32'd1);
        chk("t3_busy2", 32'(busy2), 32'd1);
        chk("t3_main_idle", 32'(busy), 32'd0);
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        chk("t3_cnt1", 32'(frame_cnt2), 32'd1);
        chk("t3_gen_en_run", 32'(gen_en2), 32'd1);
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        chk("t3_cnt2", 32'(frame_cnt2), 32'd2);
        chk("t3_gen_en_drain", 32'(gen_en2), 32'd0);
        chk("t3_busy_drain", 32'(busy2), 32'd1);
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        @(negedge clk);
        chk("t3_busy_idle", 32'(busy2), 32'd0);
        chk("t3_cnt_final", 32'(frame_cnt2), 32'd2);

        // short line sets sticky geo_err
        chan_sel = 2'd2;
        pulse_start();
        stream = 1'b1;
        send_vs();
        send_lines(V, 1, -1, 2'd0);
        send_vs();
        chk("t4_geo_frame1", 32'(geo_err), 32'd1);
        chk("t4_cnt1", 32'(frame_cnt), 32'd1);
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        chk("t4_geo_sticky", 32'(geo_err), 32'd1);
        pulse_stop();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        stream = 1'b0;
        @(negedge clk);
        chk("t4_geo_idle", 32'(geo_err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // start and stop together in IDLE: start wins and clears
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("t4_ss_busy", 32'(busy), 32'd1);
        chk("t4_ss_gen_en", 32'(gen_en), 32'd1);
        chk("t4_restart_geo", 32'(geo_err), 32'd0);
        chk("t4_restart_cnt", 32'(frame_cnt), 32'd0);

        // five lines in a frame
        stream = 1'b1;
        send_vs();
        send_lines(V + 1, -1, -1, 2'd0);
        @(negedge clk);
        chk("t5_geo_pre", 32'(geo_err), 32'd0);
        send_vs();
        chk("t5_geo_set", 32'(geo_err), 32'd1);
        chk("t5_cnt1", 32'(frame_cnt), 32'd1);
        pulse_stop();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        stream = 1'b0;
        @(negedge clk);
        chk("t5_cnt_final", 32'(frame_cnt), 32'd2);
        chk("t5_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-RUN
        chan_sel = 2'd3;
        pulse_start();
        stream = 1'b1;
        send_vs();
        send_lines(2, -1, -1, 2'd0);
        @(negedge clk);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        step();
        rst_n = 1'b0;
        stream = 1'b0;
        #1;
        chk("t6_rst_gen_en", 32'(gen_en), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_rst_geo", 32'(geo_err), 32'd0);
        chk("t6_rst_vga", 32'({vga_de, vga_hs, vga_vs, vga_data}), 32'd0);
        chk("t6_queue_empty", 32'(q.size()), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        @(negedge clk);
        chk("t6_no_stream_busy", 32'(busy), 32'd0);
        chk("t6_no_stream_gen", 32'(gen_en), 32'd0);
        pulse_start();
        stream = 1'b1;
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        pulse_stop();
        send_vs();
        send_lines(V, -1, -1, 2'd0);
        send_vs();
        stream = 1'b0;
        @(negedge clk);
        chk("t6_cnt", 32'(frame_cnt), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);

        repeat (3) step();
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
